// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between pipeline writeback
//               and a 2-entry FIFO of long-latency results, with anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_valid,
    input  logic            pipe_fp,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    output logic            pipe_stall,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic            lu_fp,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            wb_we_int,
    output logic            wb_we_fp,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            lu_pending
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [1:0]      r_fifo_fp;
    logic [4:0]      r_fifo_rd   [0:1];
    logic [XLEN-1:0] r_fifo_data [0:1];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic [3:0]      r_starve_cnt;

    logic            r_wb_we_int;
    logic            r_wb_we_fp;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic            w_empty;
    logic            w_full;
    logic            w_force;
    logic            w_push;
    logic            w_pop;
    logic            w_grant_pipe;
    logic            w_grant_fifo;
    logic            w_grant;
    logic            w_src_fp;
    logic [4:0]      w_src_rd;
    logic [XLEN-1:0] w_src_data;

    assign w_empty = (r_count == 2'd0);
    assign w_full  = (r_count == 2'd2);
    // Forcing depends only on registered state so pipe_stall has no input path.
    assign w_force = (r_starve_cnt == c_starve_max) && !w_empty;
    assign w_push  = lu_valid && !w_full;

    always_comb begin
        w_grant_pipe = 1'b0;
        w_grant_fifo = 1'b0;
        if (w_force) begin
            w_grant_fifo = 1'b1;
        end else if (pipe_valid) begin
            w_grant_pipe = 1'b1;
        end else if (!w_empty) begin
            w_grant_fifo = 1'b1;
        end
    end

    assign w_pop   = w_grant_fifo;
    assign w_grant = w_grant_pipe || w_grant_fifo;

    always_comb begin
        w_src_fp   = pipe_fp;
        w_src_rd   = pipe_rd;
        w_src_data = pipe_data;
        if (w_grant_fifo) begin
            w_src_fp   = r_fifo_fp[r_rd_ptr];
            w_src_rd   = r_fifo_rd[r_rd_ptr];
            w_src_data = r_fifo_data[r_rd_ptr];
        end
    end

    // Payload storage needs no reset: validity is carried by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_fp[r_wr_ptr]   <= lu_fp;
            r_fifo_rd[r_wr_ptr]   <= lu_rd;
            r_fifo_data[r_wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_starve_cnt <= 4'd0;
            r_wb_we_int  <= 1'b0;
            r_wb_we_fp   <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (w_empty || w_pop) begin
                r_starve_cnt <= 4'd0;
            end else if (w_grant_pipe && (r_starve_cnt != c_starve_max)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            // Writes to x0 still consume the grant but never raise an enable.
            r_wb_we_int <= w_grant && !w_src_fp && (w_src_rd != 5'd0);
            r_wb_we_fp  <= w_grant && w_src_fp;
            if (w_grant) begin
                r_wb_rd   <= w_src_rd;
                r_wb_data <= w_src_data;
            end
        end
    end

    assign pipe_stall = w_force;
    assign lu_ready   = !w_full;
    assign lu_pending = !w_empty;
    assign wb_we_int  = r_wb_we_int;
    assign wb_we_fp   = r_wb_we_fp;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed self-checking bench for wb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pipe_valid = 1'b0;
    logic            pipe_fp = 1'b0;
    logic [4:0]      pipe_rd = 5'd0;
    logic [XLEN-1:0] pipe_data = '0;
    logic            pipe_stall;
    logic            lu_valid = 1'b0;
    logic            lu_ready;
    logic            lu_fp = 1'b0;
    logic [4:0]      lu_rd = 5'd0;
    logic [XLEN-1:0] lu_data = '0;
    logic            wb_we_int;
    logic            wb_we_fp;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            lu_pending;

    int n_checks = 0;
    int n_errors = 0;

    wb_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_valid (pipe_valid),
        .pipe_fp    (pipe_fp),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_fp      (lu_fp),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .wb_we_int  (wb_we_int),
        .wb_we_fp   (wb_we_fp),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .lu_pending (lu_pending)
    );

    initial forever #5 clk = ~clk;

    task automatic idle_inputs();
        pipe_valid = 1'b0; pipe_fp = 1'b0; pipe_rd = 5'd0; pipe_data = '0;
        lu_valid = 1'b0; lu_fp = 1'b0; lu_rd = 5'd0; lu_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (wb_we_int !== 1'b0) begin n_errors++; $display("FAIL reset_we_int: got %b want 0", wb_we_int); end
        n_checks++; if (wb_we_fp !== 1'b0) begin n_errors++; $display("FAIL reset_we_fp: got %b want 0", wb_we_fp); end
        n_checks++; if (wb_rd !== 5'd0) begin n_errors++; $display("FAIL reset_rd: got %0d want 0", wb_rd); end
        n_checks++; if (wb_data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h want 0", wb_data); end
        n_checks++; if (pipe_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", pipe_stall); end
        n_checks++; if (lu_ready !== 1'b1) begin n_errors++; $display("FAIL reset_lu_ready: got %b want 1", lu_ready); end
        n_checks++; if (lu_pending !== 1'b0) begin n_errors++; $display("FAIL reset_pending: got %b want 0", lu_pending); end
        rst_n = 1'b1;
    endtask

    task automatic test_pipe_write();
        @(negedge clk);
        pipe_valid = 1'b1; pipe_fp = 1'b0; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        n_checks++; if (pipe_stall !== 1'b0) begin n_errors++; $display("FAIL pipe_stall: got %b want 0", pipe_stall); end
        @(negedge clk);
        idle_inputs();
        n_checks++; if (wb_we_int !== 1'b1) begin n_errors++; $display("FAIL pipe_we_int: got %b want 1", wb_we_int); end
        n_checks++; if (wb_we_fp !== 1'b0) begin n_errors++; $display("FAIL pipe_we_fp: got %b want 0", wb_we_fp); end
        n_checks++; if (wb_rd !== 5'd5) begin n_errors++; $display("FAIL pipe_rd: got %0d want 5", wb_rd); end
        n_checks++; if (wb_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL pipe_data: got %h want deadbeef", wb_data); end
        @(negedge clk);
        n_checks++; if (wb_we_int !== 1'b0) begin n_errors++; $display("FAIL pipe_we_one_cycle: got %b want 0", wb_we_int); end
        n_checks++; if (wb_rd !== 5'd5 || wb_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL pipe_hold: got %0d/%h want 5/deadbeef", wb_rd, wb_data); end
    endtask

    task automatic test_x0();
        pipe_valid = 1'b1; pipe_fp = 1'b0; pipe_rd = 5'd0; pipe_data = 32'h1234;
        @(negedge clk);
        pipe_fp = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h3F800000;
        n_checks++; if (wb_we_int !== 1'b0 || wb_we_fp !== 1'b0) begin n_errors++; $display("FAIL x0_no_we: got int=%b fp=%b want 0/0", wb_we_int, wb_we_fp); end
        n_checks++; if (pipe_stall !== 1'b0) begin n_errors++; $display("FAIL x0_stall: got %b want 0", pipe_stall); end
        n_checks++; if (wb_data !== 32'h1234) begin n_errors++; $display("FAIL x0_data: got %h want 1234", wb_data); end
        @(negedge clk);
        idle_inputs();
        n_checks++; if (wb_we_fp !== 1'b1 || wb_we_int !== 1'b0) begin n_errors++; $display("FAIL fp0_we: got int=%b fp=%b want 0/1", wb_we_int, wb_we_fp); end
        n_checks++; if (wb_rd !== 5'd0 || wb_data !== 32'h3F800000) begin n_errors++; $display("FAIL fp0_rd_data: got %0d/%h want 0/3f800000", wb_rd, wb_data); end
    endtask

    task automatic test_lu_single();
        @(negedge clk);
        n_checks++; if (lu_ready !== 1'b1) begin n_errors++; $display("FAIL lu_ready_idle: got %b want 1", lu_ready); end
        lu_valid = 1'b1; lu_fp = 1'b0; lu_rd = 5'd7; lu_data = 32'hA5A5A5A5;
        @(negedge clk);
        idle_inputs();
        n_checks++; if (lu_pending !== 1'b1) begin n_errors++; $display("FAIL lu_pending_c2: got %b want 1", lu_pending); end
        n_checks++; if (wb_we_int !== 1'b0) begin n_errors++; $display("FAIL lu_no_bypass: got %b want 0", wb_we_int); end
        @(negedge clk);
        n_checks++; if (wb_we_int !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'hA5A5A5A5) begin
            n_errors++; $display("FAIL lu_write: got we=%b rd=%0d data=%h want 1/7/a5a5a5a5", wb_we_int, wb_rd, wb_data); end
        n_checks++; if (lu_pending !== 1'b0) begin n_errors++; $display("FAIL lu_pending_c3: got %b want 0", lu_pending); end
    endtask

    task automatic test_starvation();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_checks++; if (pipe_stall !== ((c == 6) || (c == 11))) begin
                n_errors++; $display("FAIL starve_stall_c%0d: got %b want %b", c, pipe_stall, (c == 6) || (c == 11)); end
            if (c == 2) begin
                n_checks++; if (lu_ready !== 1'b1) begin n_errors++; $display("FAIL starve_ready_c2: got %b want 1", lu_ready); end
            end
            if (c == 3) begin
                n_checks++; if (lu_ready !== 1'b0 || lu_pending !== 1'b1) begin n_errors++; $display("FAIL starve_full_c3: got ready=%b pend=%b want 0/1", lu_ready, lu_pending); end
            end
            if (c == 6) begin
                n_checks++; if (wb_we_int !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h1005) begin
                    n_errors++; $display("FAIL starve_pipe_c6: got we=%b rd=%0d data=%h want 1/3/1005", wb_we_int, wb_rd, wb_data); end
            end
            if (c == 7) begin
                n_checks++; if (wb_we_int !== 1'b1 || wb_rd !== 5'd10 || wb_data !== 32'hAAAA0001) begin
                    n_errors++; $display("FAIL starve_head_a: got we=%b rd=%0d data=%h want 1/10/aaaa0001", wb_we_int, wb_rd, wb_data); end
                n_checks++; if (lu_ready !== 1'b1) begin n_errors++; $display("FAIL starve_ready_c7: got %b want 1", lu_ready); end
            end
            if (c == 8) begin
                n_checks++; if (wb_we_int !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h1007) begin
                    n_errors++; $display("FAIL starve_pipe_c8: got we=%b rd=%0d data=%h want 1/3/1007", wb_we_int, wb_rd, wb_data); end
            end
            if (c == 12) begin
                n_checks++; if (wb_we_fp !== 1'b1 || wb_we_int !== 1'b0 || wb_rd !== 5'd11 || wb_data !== 32'hBBBB0002) begin
                    n_errors++; $display("FAIL starve_head_b: got fp=%b int=%b rd=%0d data=%h want 1/0/11/bbbb0002", wb_we_fp, wb_we_int, wb_rd, wb_data); end
                n_checks++; if (lu_pending !== 1'b0) begin n_errors++; $display("FAIL starve_pending_c12: got %b want 0", lu_pending); end
            end
            pipe_valid = 1'b1; pipe_fp = 1'b0; pipe_rd = 5'd3; pipe_data = 32'h1000 + 32'(c);
            lu_valid = (c == 1) || (c == 2);
            lu_fp    = (c == 2);
            lu_rd    = (c == 1) ? 5'd10 : 5'd11;
            lu_data  = (c == 1) ? 32'hAAAA0001 : 32'hBBBB0002;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'hC0000001;
        @(negedge clk);
        lu_rd = 5'd13; lu_data = 32'hC0000002;
        n_checks++; if (lu_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_c2: got %b want 1", lu_ready); end
        @(negedge clk);
        lu_rd = 5'd14; lu_data = 32'hC0000003;
        n_checks++; if (lu_pending !== 1'b1 || lu_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_count_c3: got pend=%b ready=%b want 1/1", lu_pending, lu_ready); end
        n_checks++; if (wb_we_int !== 1'b1 || wb_rd !== 5'd12 || wb_data !== 32'hC0000001) begin
            n_errors++; $display("FAIL b2b_a: got we=%b rd=%0d data=%h want 1/12/c0000001", wb_we_int, wb_rd, wb_data); end
        @(negedge clk);
        idle_inputs();
        n_checks++; if (lu_pending !== 1'b1) begin n_errors++; $display("FAIL b2b_count_c4: got %b want 1", lu_pending); end
        n_checks++; if (wb_we_int !== 1'b1 || wb_rd !== 5'd13 || wb_data !== 32'hC0000002) begin
            n_errors++; $display("FAIL b2b_b: got we=%b rd=%0d data=%h want 1/13/c0000002", wb_we_int, wb_rd, wb_data); end
        @(negedge clk);
        n_checks++; if (wb_we_int !== 1'b1 || wb_rd !== 5'd14 || wb_data !== 32'hC0000003) begin
            n_errors++; $display("FAIL b2b_c: got we=%b rd=%0d data=%h want 1/14/c0000003", wb_we_int, wb_rd, wb_data); end
        n_checks++; if (lu_pending !== 1'b0) begin n_errors++; $display("FAIL b2b_drained: got %b want 0", lu_pending); end
    endtask

    task automatic test_async_reset();
        pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h99;
        lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 32'hD0;
        @(negedge clk);
        lu_rd = 5'd21; lu_data = 32'hE0;
        @(negedge clk);
        lu_valid = 1'b0;
        n_checks++; if (lu_ready !== 1'b0 || wb_we_int !== 1'b1) begin n_errors++; $display("FAIL ar_setup: got ready=%b we=%b want 0/1", lu_ready, wb_we_int); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (wb_we_int !== 1'b0 || wb_we_fp !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0) begin
            n_errors++; $display("FAIL ar_outputs: got int=%b fp=%b rd=%0d data=%h want 0/0/0/0", wb_we_int, wb_we_fp, wb_rd, wb_data); end
        n_checks++; if (lu_ready !== 1'b1 || lu_pending !== 1'b0 || pipe_stall !== 1'b0) begin
            n_errors++; $display("FAIL ar_status: got ready=%b pend=%b stall=%b want 1/0/0", lu_ready, lu_pending, pipe_stall); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (wb_we_int !== 1'b0 || wb_we_fp !== 1'b0 || lu_pending !== 1'b0) begin
                n_errors++; $display("FAIL ar_no_write_%0d: got int=%b fp=%b pend=%b want 0/0/0", c, wb_we_int, wb_we_fp, lu_pending); end
        end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_x0();
        test_lu_single();
        test_starvation();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port among the in-order pipeline writeback (the MEM/WB register outputs) and results returned by the long-latency unit (iterative divide, FP div/sqrt). It sits between the MEM/WB register and the integer/FP register files. It buffers long-latency results in a 2-entry FIFO and gives the pipeline priority. A starvation counter guarantees forward progress for buffered results by stalling the pipeline for one cycle when needed. All outputs are registered.

## Interface
- XLEN, 32, data width of results and write port
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may lose arbitration before the pipeline is stalled (legal range 1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_valid  in  1  pipeline WB result present (MEM/WB reg_write or fp_reg_write)
- pipe_fp  in  1  1 = destination is FP register file
- pipe_rd  in  5  destination register
- pipe_data  in  XLEN  result (already muxed ALU/mem/FPU)
- pipe_stall  out  1  pipeline result not accepted this cycle; MEM/WB and earlier stages must hold
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  FIFO can accept (= FIFO not full)
- lu_fp  in  1  FP destination
- lu_rd  in  5  destination register
- lu_data  in  XLEN  result
- wb_we_int  out  1  integer RF write enable
- wb_we_fp  out  1  FP RF write enable
- wb_rd  out  5  write address
- wb_data  out  XLEN  write data
- lu_pending  out  1  FIFO non-empty (used by hazard unit)

## Operation
- FIFO: 2 entries {fp, rd, data}, read/write pointers with wrap, count 0..2. Push on lu_valid && lu_ready. Pop when the head is granted. Push and pop in the same cycle is legal when count is 1. With count 2, lu_ready = 0, so there is no push, even if a pop occurs.
- No bypass: a pushed entry becomes eligible the cycle after the push.
- starve_cnt (4 bits): cleared when the FIFO is empty or the head is popped. Increments when the FIFO is non-empty and the pipeline takes the port. Saturates at STARVE_MAX.
- Arbitration, each cycle, in priority order:
  1. force = (starve_cnt == STARVE_MAX) && FIFO non-empty. When force is set: grant the FIFO head and set pipe_stall = 1 (combinational from registered state only; independent of pipe_valid).
  2. Otherwise, if pipe_valid: grant the pipeline. pipe_stall = 0.
  3. Otherwise, if the FIFO is non-empty: grant the head.
  4. Otherwise: no grant.
- Write-port register on grant:
  - wb_rd and wb_data take the granted source's values.
  - wb_we_fp = src_fp.
  - wb_we_int = !src_fp && (rd != 0).
  - An integer write to x0 is accepted/popped but produces no write enable.
- No grant: wb_we_int = wb_we_fp = 0. wb_rd and wb_data hold their previous values.
- lu_pending = (count != 0).

## Timing
- Reset (async assert, sync release): FIFO count and pointers = 0, starve_cnt = 0. Outputs: wb_we_int = wb_we_fp = 0, wb_rd = 0, wb_data = 0, pipe_stall = 0, lu_ready = 1, lu_pending = 0. In-flight FIFO entries are discarded.
- Pipeline latency: pipe_valid accepted in cycle N → write enables high in cycle N+1, for exactly one cycle.
- Long-latency latency: handshake in cycle N with an idle pipeline → write in cycle N+2.
- pipe_stall is high for exactly one cycle per force event. The next force event requires STARVE_MAX further lost cycles.
- Simultaneous push and pop at count 1: count stays 1. The new entry becomes head in the following cycle.
- lu_ready deasserts in the cycle after count reaches 2. It reasserts in the cycle after a pop.

## Test plan
- Reset, then pipe_valid with rd=5, int, data=0xDEADBEEF in cycle 1 → cycle 2: wb_we_int=1, wb_rd=5, wb_data=0xDEADBEEF, wb_we_fp=0.
- Integer rd=0, data=0x1234 → no write enables; pipe_stall stays 0. FP rd=0, data=0x3F800000 → wb_we_fp=1, wb_rd=0.
- Idle pipeline; lu push {int, rd=7, 0xA5A5A5A5} in cycle 1 → lu_pending=1 in cycle 2, write in cycle 3, lu_pending=0 in cycle 3.
- Two lu pushes in back-to-back cycles with the pipeline continuously valid → lu_ready=0 after the 2nd push. After 4 lost cycles, pipe_stall=1 for one cycle and the head is written. The 2nd entry is written after 4 further lost cycles.
- Push and pop in the same cycle at count 1 → count remains 1; entries emerge in order A, B, C.
- Assert rst_n=0 asynchronously with 2 entries queued and a write in flight → all outputs go to reset values immediately; no queued entry is written after release.
